// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared state codes, opcodes and counter sizing helper
package muldiv_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // One extra bit over clog2 keeps the counter wide enough for any word_size.
   function automatic int counter_width(input int ws);
      return $clog2(ws) + 1;
   endfunction

endpackage

// File: rtl/muldiv_sequencer_adder_subtractor.sv
// rtl/muldiv_sequencer_adder_subtractor.sv - word_size adder/subtractor with carry out
// Subtract is a + ~b + 1, so carry out = 1 means no borrow.
module muldiv_sequencer_adder_subtractor #(
   parameter int word_size = 8
) (
   input  logic [word_size-1:0] i_a,
   input  logic [word_size-1:0] i_b,
   input  logic                 i_subtract,
   output logic [word_size-1:0] o_sum,
   output logic                 o_carry
);

   logic [word_size-1:0] w_b_eff;
   logic [word_size:0]   w_total;

   assign w_b_eff = i_subtract ? ~i_b : i_b;
   assign w_total = {1'b0, i_a} + {1'b0, w_b_eff} + {{word_size{1'b0}}, i_subtract};
   assign o_sum   = w_total[word_size-1:0];
   assign o_carry = w_total[word_size];

endmodule

// File: rtl/muldiv_sequencer_step_counter.sv
// rtl/muldiv_sequencer_step_counter.sv - loadable up-counter with terminal-count flag
module muldiv_sequencer_step_counter
   import muldiv_sequencer_pkg::*;
#(
   parameter int word_size = 8,
   parameter int CW        = counter_width(word_size)
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_value,
   input  logic          i_enable,
   output logic          o_tc
);

   logic [CW-1:0] r_count;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_tc = (r_count == CW'(word_size - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - sequential unsigned multiply/divide around one shared adder
// Shift-and-add multiply and restoring divide, one step per clock.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int word_size = 8
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic                 i_op,
   input  logic [word_size-1:0] i_operand_a,
   input  logic [word_size-1:0] i_operand_b,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [word_size-1:0] o_result_lo,
   output logic [word_size-1:0] o_result_hi,
   output logic                 o_div_by_zero
);

   localparam int CW = counter_width(word_size);

   state_t               r_state;
   state_t               w_next_state;
   logic                 w_accept;
   logic                 w_step;
   logic                 w_dbz_step;
   logic                 w_last;

   logic                 r_op;
   logic [word_size-1:0] r_b;
   logic [word_size-1:0] r_hi;
   logic [word_size-1:0] r_lo;
   logic                 r_dbz;

   logic [word_size-1:0] w_shift;
   logic                 w_ov;
   logic                 w_take;
   logic [word_size-1:0] w_add_a;
   logic [word_size-1:0] w_sum;
   logic                 w_carry;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      w_dbz_step   = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               w_accept     = 1'b1;
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_RUN: begin
            if ((r_op == OP_DIV) && (r_b == '0)) begin
               w_dbz_step   = 1'b1;
               w_next_state = ST_DONE;
            end else begin
               w_step = 1'b1;
               if (w_last) begin
                  w_next_state = ST_DONE;
               end
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Divide shifts the next dividend bit into the remainder before the trial subtract.
   assign w_shift = {r_hi[word_size-2:0], r_lo[word_size-1]};
   assign w_ov    = r_hi[word_size-1];
   assign w_take  = w_ov | w_carry;
   assign w_add_a = (r_op == OP_DIV) ? w_shift : r_hi;

   muldiv_sequencer_adder_subtractor #(
      .word_size (word_size)
   ) u_addsub (
      .i_a        (w_add_a),
      .i_b        (r_b),
      .i_subtract (r_op),
      .o_sum      (w_sum),
      .o_carry    (w_carry)
   );

   muldiv_sequencer_step_counter #(
      .word_size (word_size),
      .CW        (CW)
   ) u_counter (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_load       (w_accept),
      .i_load_value ({CW{1'b0}}),
      .i_enable     (w_step),
      .o_tc         (w_last)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_op  <= OP_MUL;
         r_b   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_dbz <= 1'b0;
      end else if (w_accept) begin
         r_op  <= i_op;
         r_b   <= i_operand_b;
         r_hi  <= '0;
         r_lo  <= i_operand_a;
         r_dbz <= 1'b0;
      end else if (w_dbz_step) begin
         // r_lo still holds the untouched dividend here.
         r_lo  <= '1;
         r_hi  <= r_lo;
         r_dbz <= 1'b1;
      end else if (w_step) begin
         if (r_op == OP_MUL) begin
            if (r_lo[0]) begin
               r_hi <= {w_carry, w_sum[word_size-1:1]};
               r_lo <= {w_sum[0], r_lo[word_size-1:1]};
            end else begin
               r_hi <= {1'b0, r_hi[word_size-1:1]};
               r_lo <= {r_hi[0], r_lo[word_size-1:1]};
            end
         end else begin
            r_hi <= w_take ? w_sum : w_shift;
            r_lo <= {r_lo[word_size-2:0], w_take};
         end
      end
   end

   assign o_busy        = (r_state == ST_RUN);
   assign o_done        = (r_state == ST_DONE);
   assign o_result_lo   = r_lo;
   assign o_result_hi   = r_hi;
   assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

   localparam int WS = 8;

   logic          clk;
   logic          reset;
   logic          start;
   logic          op;
   logic [WS-1:0] a;
   logic [WS-1:0] b;
   logic          busy;
   logic          done;
   logic [WS-1:0] res_lo;
   logic [WS-1:0] res_hi;
   logic          dbz;

   int n_checks;
   int n_fail;

   muldiv_sequencer #(.word_size(WS)) dut (
      .i_clock       (clk),
      .i_reset       (reset),
      .i_start       (start),
      .i_op          (op),
      .i_operand_a   (a),
      .i_operand_b   (b),
      .o_busy        (busy),
      .o_done        (done),
      .o_result_lo   (res_lo),
      .o_result_hi   (res_hi),
      .o_div_by_zero (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: countdown to done plus arithmetic results from plain * / %.
   bit          m_known = 0;
   bit          m_busy, m_done, m_valid;
   int          m_left;
   logic [WS-1:0] m_lo, m_hi, p_lo, p_hi;
   logic        m_dbz, p_dbz;

   always @(posedge clk) begin
      logic [2*WS-1:0] prod;
      if (reset) begin
         m_known = 1; m_busy = 0; m_done = 0; m_valid = 1;
         m_left = 0; m_lo = '0; m_hi = '0; m_dbz = 0;
      end else if (m_known) begin
         if (!m_busy && start) begin
            m_busy = 1; m_done = 0; m_valid = 0; m_dbz = 0;
            if (op) begin
               if (b == 0) begin
                  m_left = 1; p_lo = '1; p_hi = a; p_dbz = 1;
               end else begin
                  m_left = WS; p_lo = a / b; p_hi = a % b; p_dbz = 0;
               end
            end else begin
               prod = {{WS{1'b0}}, a} * {{WS{1'b0}}, b};
               m_left = WS; p_lo = prod[WS-1:0]; p_hi = prod[2*WS-1:WS]; p_dbz = 0;
            end
         end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1; m_valid = 1;
               m_lo = p_lo; m_hi = p_hi; m_dbz = p_dbz;
            end
         end else begin
            m_done = 0;
         end
      end
   end

   task automatic check1(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_known) begin
         check1("model_busy", {7'd0, busy}, {7'd0, m_busy});
         check1("model_done", {7'd0, done}, {7'd0, m_done});
         check1("model_dbz",  {7'd0, dbz},  {7'd0, m_dbz});
         if (m_valid) begin
            check1("model_lo", res_lo, m_lo);
            check1("model_hi", res_hi, m_hi);
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_op(input string name, input logic o, input logic [WS-1:0] xa,
                         input logic [WS-1:0] xb, input logic [WS-1:0] e_lo,
                         input logic [WS-1:0] e_hi, input logic e_dbz, input int e_lat);
      int lat;
      start = 1'b1; op = o; a = xa; b = xb;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check1({name, "_latency"}, 8'(lat), 8'(e_lat));
      check1({name, "_lo"}, res_lo, e_lo);
      check1({name, "_hi"}, res_hi, e_hi);
      check1({name, "_dbz"}, {7'd0, dbz}, {7'd0, e_dbz});
   endtask

   task automatic no_done_for(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      check1(name, 8'(seen), 8'd0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      @(negedge clk);
      do_reset();
      check1("reset_busy", {7'd0, busy}, 8'd0);
      check1("reset_done", {7'd0, done}, 8'd0);
      check1("reset_lo", res_lo, 8'd0);
      check1("reset_hi", res_hi, 8'd0);
      check1("reset_dbz", {7'd0, dbz}, 8'd0);

      run_op("mul_13x11", 1'b0, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0, 8);
      repeat (2) @(negedge clk);
      run_op("mul_255x255", 1'b0, 8'd255, 8'd255, 8'h01, 8'hFE, 1'b0, 8);
      run_op("mul_2x3_b2b", 1'b0, 8'd2, 8'd3, 8'd6, 8'd0, 1'b0, 8);
      @(negedge clk);
      run_op("div_200_7", 1'b1, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8);
      run_op("div_255_1", 1'b1, 8'd255, 8'd1, 8'hFF, 8'd0, 1'b0, 8);
      run_op("div_5_9", 1'b1, 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
      @(negedge clk);
      run_op("div_42_0", 1'b1, 8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1);
      repeat (3) @(negedge clk);
      check1("hold_lo", res_lo, 8'hFF);
      check1("hold_dbz", {7'd0, dbz}, 8'd1);

      // Start during RUN must be ignored.
      begin
         int lat;
         int dones;
         start = 1'b1; op = 1'b0; a = 8'd13; b = 8'd11;
         @(negedge clk);
         start = 1'b0;
         lat = 0;
         dones = 0;
         for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
               start = 1'b1; op = 1'b1; a = 8'd99; b = 8'd3;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
               dones++;
               if (dones == 1) begin
                  lat = i + 1;
                  check1("ignored_start_lo", res_lo, 8'd143);
                  check1("ignored_start_hi", res_hi, 8'd0);
               end
            end
         end
         check1("ignored_start_latency", 8'(lat), 8'd8);
         check1("ignored_start_done_count", 8'(dones), 8'd1);
      end

      // Reset mid-divide discards the operation.
      start = 1'b1; op = 1'b1; a = 8'd200; b = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check1("midreset_busy", {7'd0, busy}, 8'd0);
      check1("midreset_done", {7'd0, done}, 8'd0);
      check1("midreset_lo", res_lo, 8'd0);
      check1("midreset_hi", res_hi, 8'd0);
      no_done_for("midreset_no_done", 12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
